// File: rtl/rc5_pkg.sv
// Shared RC5-16 constants, FSM state type and helpers for key schedule and round engine.
package rc5_pkg;

  localparam int unsigned W          = 16;
  localparam int unsigned MAX_ROUNDS = 16;
  localparam int unsigned C_WORDS    = 8;
  localparam int unsigned T_MAX      = 2 * (MAX_ROUNDS + 1);

  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StMix,
    StDone
  } rc5_state_e;

  function automatic logic [W-1:0] rotl16(input logic [W-1:0] x, input logic [3:0] amt);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << amt;
    return dbl[2*W-1:W];
  endfunction

  // t = 2*(r_eff+1), r saturating at MAX_ROUNDS.
  function automatic logic [5:0] table_depth(input logic [4:0] r);
    logic [4:0] r_eff;
    r_eff = (r > 5'd16) ? 5'd16 : r;
    return {r_eff, 1'b0} + 6'd2;
  endfunction

  // Index of the final mix iteration: 3*max(t,8) - 1.
  function automatic logic [6:0] mix_last(input logic [5:0] t);
    logic [6:0] m;
    m = (t < 6'd8) ? 7'd8 : {1'b0, t};
    return m + m + m - 7'd1;
  endfunction

endpackage

// File: rtl/rc5_mix_unit.sv
// One RC5 key-mix iteration: the chained add/rotate path producing A' and B'.
module rc5_mix_unit
  import rc5_pkg::*;
(
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] l_j,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] a_new,
  output logic [W-1:0] b_new
);

  logic [W-1:0] a_sum;
  logic [W-1:0] ab_sum;
  logic [W-1:0] b_sum;

  always_comb begin
    a_sum  = s_i + a + b;
    a_new  = rotl16(a_sum, 4'd3);
    ab_sum = a_new + b;
    b_sum  = l_j + ab_sum;
    b_new  = rotl16(b_sum, ab_sum[3:0]);
  end

endmodule

// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: expands a 128-bit key into S[0..t-1] and exposes it on a read port.
module rc5_key_expand
  import rc5_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4:0]     num_rounds,
  input  logic [127:0]   key,
  output logic           busy,
  output logic           done,
  output logic           key_valid,
  output logic [5:0]     table_size,
  input  logic [5:0]     s_rd_addr,
  output logic [W-1:0]   s_rd_data
);

  rc5_state_e state_q, state_d;

  logic [W-1:0] s_q [T_MAX];
  logic [W-1:0] l_q [C_WORDS];

  logic [5:0]   i_q;
  logic [2:0]   j_q;
  logic [6:0]   k_q;
  logic [6:0]   k_last_q;
  logic [5:0]   t_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] init_prev_q;
  logic         key_valid_q;

  logic [W-1:0] init_word;
  logic [W-1:0] a_new;
  logic [W-1:0] b_new;
  logic         i_wrap;

  rc5_mix_unit u_mix (
    .s_i   (s_q[i_q]),
    .l_j   (l_q[j_q]),
    .a     (a_q),
    .b     (b_q),
    .a_new (a_new),
    .b_new (b_new)
  );

  assign i_wrap    = (i_q == t_q - 6'd1);
  assign init_word = (i_q == 6'd0) ? P16 : init_prev_q + Q16;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StInit;
      StInit:  if (i_wrap) state_d = StMix;
      StMix:   if (k_q == k_last_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      key_valid_q <= 1'b0;
      t_q         <= '0;
      k_last_q    <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      init_prev_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            t_q         <= table_depth(num_rounds);
            k_last_q    <= mix_last(table_depth(num_rounds));
            key_valid_q <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
          end
        end
        StInit: begin
          init_prev_q <= init_word;
          i_q         <= i_wrap ? 6'd0 : i_q + 6'd1;
        end
        StMix: begin
          a_q <= a_new;
          b_q <= b_new;
          i_q <= i_wrap ? 6'd0 : i_q + 6'd1;
          j_q <= j_q + 3'd1;
          k_q <= k_q + 7'd1;
        end
        StDone: key_valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Table storage carries no reset; key_valid gates every read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int n = 0; n < C_WORDS; n++) begin
              l_q[n] <= key[W*n +: W];
            end
          end
        end
        StInit: s_q[i_q] <= init_word;
        StMix: begin
          s_q[i_q] <= a_new;
          l_q[j_q] <= b_new;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_rd_data = '0;
    if (key_valid_q && (s_rd_addr < t_q)) begin
      s_rd_data = s_q[s_rd_addr];
    end
  end

  assign busy       = (state_q == StInit) || (state_q == StMix);
  assign done       = (state_q == StDone);
  assign key_valid  = key_valid_q;
  assign table_size = t_q;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand against a loop-level RC5 key schedule model.
`timescale 1ns/1ps
module tb_rc5_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [5:0]   table_size;
  logic [5:0]   s_rd_addr;
  logic [15:0]  s_rd_data;

  int checks;
  int failures;

  logic [15:0] m_s [34];
  int          m_t;

  rc5_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_rounds (num_rounds),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .key_valid  (key_valid),
    .table_size (table_size),
    .s_rd_addr  (s_rd_addr),
    .s_rd_data  (s_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
    int s;
    s = n % 16;
    return 16'((x << s) | (x >> (16 - s)));
  endfunction

  function automatic int t_of(input int r);
    return 2 * (((r > 16) ? 16 : r) + 1);
  endfunction

  function automatic int latency_of(input int r);
    int t;
    t = t_of(r);
    return t + 3 * ((t > 8) ? t : 8) + 1;
  endfunction

  // Textbook RC5 key schedule: init pass then 3*max(t,c) mix iterations.
  task automatic build_model(input logic [127:0] k, input int r);
    logic [15:0] l [8];
    logic [15:0] a, b;
    int i, j, n_iter;
    m_t = t_of(r);
    for (int n = 0; n < 8; n++) l[n] = k[16*n +: 16];
    m_s[0] = 16'hB7E1;
    for (int n = 1; n < m_t; n++) m_s[n] = m_s[n-1] + 16'h9E37;
    a = 0; b = 0; i = 0; j = 0;
    n_iter = 3 * ((m_t > 8) ? m_t : 8);
    for (int n = 0; n < n_iter; n++) begin
      a = rotl(m_s[i] + a + b, 3);
      b = rotl(l[j] + a + b, int'(16'(a + b)));
      m_s[i] = a;
      l[j] = b;
      i = (i + 1) % m_t;
      j = (j + 1) % 8;
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Enters at posedge+1 (cycle 0), returns in the done cycle.
  task automatic expand(input logic [127:0] k, input logic [4:0] r, input int ign_a,
                        input int ign_b, output int done_cyc, output int bad);
    int exp_done;
    exp_done = latency_of(int'(r));
    done_cyc = -1;
    bad = 0;
    key = k;
    num_rounds = r;
    start = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == ign_a || cyc == ign_b) begin
        start = 1'b1;
        key = rand_key();
        num_rounds = 5'($urandom_range(0, 31));
      end
      s_rd_addr = 6'($urandom_range(0, 63));
      #1;
      if (busy !== (cyc < exp_done)) bad++;
      if (key_valid !== 1'b0) bad++;
      if (s_rd_data !== 16'h0) bad++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input logic [4:0] r, input int done_cyc,
                           input int bad);
    checks += 3;
    if (done_cyc !== latency_of(int'(r))) begin
      failures++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, latency_of(int'(r)));
    end
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s busy/key_valid/gap_read got=%0d bad cycles exp=0", name, bad);
    end
    if (table_size !== 6'(t_of(int'(r)))) begin
      failures++;
      $display("FAIL %s table_size got=%0d exp=%0d", name, table_size, t_of(int'(r)));
    end
  endtask

  task automatic check_after_done(input string name);
    @(posedge clk); #1;
    checks += 2;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse_width got=%b exp=0", name, done);
    end
    if (key_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s key_valid got=%b exp=1", name, key_valid);
    end
  endtask

  // Reads all 64 addresses; ends realigned at posedge+1.
  task automatic check_table(input string name, input logic [127:0] k, input int r);
    logic [15:0] exp;
    build_model(k, r);
    for (int a = 0; a < 64; a++) begin
      s_rd_addr = 6'(a);
      #1;
      exp = (a < m_t) ? m_s[a] : 16'h0;
      checks++;
      if (s_rd_data !== exp) begin
        failures++;
        $display("FAIL %s S[%0d] got=%h exp=%h", name, a, s_rd_data, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_full(input string name, input logic [127:0] k, input logic [4:0] r,
                          input int ign_a, input int ign_b);
    int dc, bad;
    expand(k, r, ign_a, ign_b, dc, bad);
    check_run(name, r, dc, bad);
    check_after_done(name);
    check_table(name, k, int'(r));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset done got=%b exp=0", done); end
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL reset key_valid got=%b exp=0", key_valid);
    end
    if (table_size !== 6'd0) begin
      failures++; $display("FAIL reset table_size got=%0d exp=0", table_size);
    end
    if (s_rd_data !== 16'h0) begin
      failures++; $display("FAIL reset s_rd_data got=%h exp=0", s_rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_key();
    run_full("zero_key_r0", 128'h0, 5'd0, -1, -1);
  endtask

  task automatic test_seq_key();
    run_full("seq_key_r12", 128'h0F0E0D0C0B0A09080706050403020100, 5'd12, -1, -1);
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 3; n++) begin
      run_full("random_key", rand_key(), 5'($urandom_range(0, 16)), -1, -1);
    end
  endtask

  task automatic test_saturate();
    logic [127:0] k;
    k = rand_key();
    run_full("saturate_r20", k, 5'd20, -1, -1);
    check_table("saturate_vs_r16", k, 16);
  endtask

  task automatic test_start_ignored();
    run_full("start_ignored", rand_key(), 5'd16, 5, 40);
  endtask

  task automatic test_reset_mid();
    int stray;
    key = rand_key();
    num_rounds = 5'd16;
    start = 1'b1;
    for (int cyc = 1; cyc <= 84; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL reset_mid busy_before got=%b exp=1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid busy got=%b exp=0", busy); end
    if (key_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid key_valid got=%b exp=0", key_valid);
    end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_mid done got=%b exp=0", done); end
    stray = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++; $display("FAIL reset_mid stray_activity got=%0d exp=0", stray);
    end
    run_full("after_reset_mid", rand_key(), 5'd9, -1, -1);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    int dc, bad;
    k1 = rand_key();
    k2 = rand_key();
    expand(k1, 5'd7, -1, -1, dc, bad);
    check_run("b2b_first", 5'd7, dc, bad);
    check_after_done("b2b_first");
    expand(k2, 5'd3, -1, -1, dc, bad);
    check_run("b2b_second", 5'd3, dc, bad);
    check_after_done("b2b_second");
    check_table("b2b_second", k2, 3);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    num_rounds = '0;
    key = '0;
    s_rd_addr = '0;
    test_reset();
    test_zero_key();
    test_seq_key();
    test_random_keys();
    test_saturate();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
